// File: rtl/ddr2pe_dispatch_pkg.sv
// rtl/ddr2pe_dispatch_pkg.sv - Opcodes, instruction field positions and target types for ddr2pe_dispatch
package ddr2pe_dispatch_pkg;

    localparam int DDR_ADDR_W_DEFAULT = 32;
    localparam int BURST_W_DEFAULT    = 8;

    localparam logic [3:0] RD_OP_I  = 4'd1;
    localparam logic [3:0] RD_OP_D  = 4'd2;
    localparam logic [3:0] RD_OP_GD = 4'd3;
    localparam logic [3:0] RD_OP_P  = 4'd4;
    localparam logic [3:0] RD_OP_A  = 4'd5;

    localparam int OP_LSB     = 58;
    localparam int BUF_ID_LSB = 52;
    localparam int DEPOOL_BIT = 50;
    localparam int CH_LSB     = 48;
    localparam int BLEN_LSB   = 40;
    localparam int SIZE_LSB   = 32;
    localparam int ADDR_LSB   = 0;

    typedef enum logic [1:0] {T_I, T_D, T_P, T_A} target_e;

    typedef struct packed {
        logic    valid;
        target_e tgt;
    } op_dec_t;

    function automatic op_dec_t decode_op(input logic [3:0] op);
        op_dec_t d;
        d.valid = 1'b1;
        d.tgt   = T_I;
        case (op)
            RD_OP_I:           d.tgt = T_I;
            RD_OP_D, RD_OP_GD: d.tgt = T_D;
            RD_OP_P:           d.tgt = T_P;
            RD_OP_A:           d.tgt = T_A;
            default:           d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ddr2pe_busy_track.sv
// rtl/ddr2pe_busy_track.sv - Single busy flag: set on issue, cleared by the target's done pulse
module ddr2pe_busy_track (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic busy
);

    // set and clr never coincide for a live target; set wins so a stray done cannot drop a fresh issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
        end else if (set) begin
            busy <= 1'b1;
        end else if (clr) begin
            busy <= 1'b0;
        end
    end

endmodule

// File: rtl/ddr2pe_dispatch.sv
// rtl/ddr2pe_dispatch.sv - Read-instruction dispatcher to i/d/p/a buffer loaders and DDR read channels
module ddr2pe_dispatch
    import ddr2pe_dispatch_pkg::*;
#(
    parameter int PE_NUM     = 16,
    parameter int PE_GRP     = 4,
    parameter int INST_W     = 64,
    parameter int DDR_CH_NUM = 2,
    parameter int DDR_ADDR_W = DDR_ADDR_W_DEFAULT,
    parameter int BURST_W    = BURST_W_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [2:0]                       layer_type,
    input  logic [7:0]                       image_width,
    input  logic                             ins_valid,
    output logic                             ins_ready,
    input  logic [INST_W-1:0]                ins,
    output logic                             ins_err,
    output logic                             ibuf_start,
    output logic                             dbuf_start,
    output logic                             pbuf_start,
    output logic                             abuf_start,
    input  logic                             ibuf_done,
    input  logic                             dbuf_done,
    input  logic                             pbuf_done,
    input  logic                             abuf_done,
    output logic [3:0]                       ibuf_conf_mode,
    output logic [3:0]                       dbuf_conf_mode,
    output logic [3:0]                       pbuf_conf_mode,
    output logic [3:0]                       abuf_conf_mode,
    output logic [PE_NUM-1:0]                ibuf_conf_mask,
    output logic [PE_NUM-1:0]                dbuf_conf_mask,
    output logic [PE_NUM-1:0]                pbuf_conf_mask,
    output logic [PE_NUM-1:0]                abuf_conf_mask,
    output logic [7:0]                       ibuf_conf_num,
    output logic [7:0]                       pbuf_conf_num,
    output logic [7:0]                       abuf_conf_num,
    output logic [3:0]                       dbuf_conf_ch_num,
    output logic [3:0]                       dbuf_conf_row_num,
    output logic [3:0]                       dbuf_conf_pix_num,
    output logic                             pbuf_conf_depool,
    output logic [DDR_CH_NUM-1:0]            ddr_start,
    input  logic [DDR_CH_NUM-1:0]            ddr_done,
    output logic [DDR_CH_NUM*DDR_ADDR_W-1:0] ddr_st_addr,
    output logic [DDR_CH_NUM*BURST_W-1:0]    ddr_burst,
    output logic [DDR_CH_NUM*DDR_ADDR_W-1:0] ddr_step,
    output logic [DDR_CH_NUM*BURST_W-1:0]    ddr_burst_num
);

    logic [3:0]  op;
    logic [5:0]  buf_id;
    logic [1:0]  ch;
    logic [7:0]  blen;
    logic [7:0]  size;
    logic [31:0] addr;
    logic        depool;
    logic        unused_ins;

    assign op         = ins[OP_LSB +: 4];
    assign buf_id     = ins[BUF_ID_LSB +: 6];
    assign depool     = ins[DEPOOL_BIT];
    assign ch         = ins[CH_LSB +: 2];
    assign blen       = ins[BLEN_LSB +: 8];
    assign size       = ins[SIZE_LSB +: 8];
    assign addr       = ins[ADDR_LSB +: 32];
    assign unused_ins = ^{ins[INST_W-1:62], ins[51]};

    op_dec_t                dec;
    logic                   id_ok;
    logic                   ch_ok;
    logic                   ch_free;
    logic                   err;
    logic                   accept;
    logic                   issue;
    logic [3:0]             busy_buf;
    logic [3:0]             set_buf;
    logic [3:0]             done_buf;
    logic [DDR_CH_NUM-1:0]  busy_ch;
    logic [DDR_CH_NUM-1:0]  set_ch;

    assign dec   = decode_op(op);
    assign id_ok = layer_type[0] ? (int'(buf_id) < PE_NUM) : (int'(buf_id) < PE_NUM / PE_GRP);

    always_comb begin
        ch_ok   = 1'b0;
        ch_free = 1'b0;
        for (int c = 0; c < DDR_CH_NUM; c++) begin
            if (int'(ch) == c) begin
                ch_ok   = 1'b1;
                ch_free = !busy_ch[c];
            end
        end
    end

    // Faulty instructions are always taken so they never block the queue behind them
    assign err       = !dec.valid || !id_ok || !ch_ok;
    assign ins_ready = err || (!busy_buf[dec.tgt] && ch_free);
    assign accept    = ins_valid && ins_ready;
    assign issue     = accept && !err;

    always_comb begin
        set_buf          = '0;
        set_buf[dec.tgt] = issue;
        for (int c = 0; c < DDR_CH_NUM; c++) begin
            set_ch[c] = issue && (int'(ch) == c);
        end
    end

    assign done_buf = {abuf_done, pbuf_done, dbuf_done, ibuf_done};

    for (genvar b = 0; b < 4; b++) begin : g_buf
        ddr2pe_busy_track u_busy (
            .clk  (clk),
            .rst  (rst),
            .set  (set_buf[b]),
            .clr  (done_buf[b]),
            .busy (busy_buf[b])
        );
    end

    logic [PE_NUM-1:0] grp_ones;
    logic [PE_NUM-1:0] mask;
    logic [3:0]        mode;

    assign grp_ones = PE_NUM'((64'd1 << PE_GRP) - 64'd1);
    assign mask     = layer_type[0] ? (PE_NUM'(1) << buf_id)
                                    : (grp_ones << (int'(buf_id) * PE_GRP));
    assign mode     = {1'b0, layer_type};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ibuf_conf_mode    <= '0;
            dbuf_conf_mode    <= '0;
            pbuf_conf_mode    <= '0;
            abuf_conf_mode    <= '0;
            ibuf_conf_mask    <= '0;
            dbuf_conf_mask    <= '0;
            pbuf_conf_mask    <= '0;
            abuf_conf_mask    <= '0;
            ibuf_conf_num     <= '0;
            pbuf_conf_num     <= '0;
            abuf_conf_num     <= '0;
            dbuf_conf_ch_num  <= '0;
            dbuf_conf_row_num <= '0;
            dbuf_conf_pix_num <= '0;
            pbuf_conf_depool  <= 1'b0;
        end else if (issue) begin
            case (dec.tgt)
                T_I: begin
                    ibuf_conf_mode <= mode;
                    ibuf_conf_mask <= mask;
                    ibuf_conf_num  <= size;
                end
                T_D: begin
                    dbuf_conf_mode    <= mode;
                    dbuf_conf_mask    <= mask;
                    dbuf_conf_ch_num  <= size[3:0];
                    dbuf_conf_row_num <= blen[3:0];
                    dbuf_conf_pix_num <= blen[7:4];
                end
                T_P: begin
                    pbuf_conf_mode   <= mode;
                    pbuf_conf_mask   <= mask;
                    pbuf_conf_num    <= size;
                    pbuf_conf_depool <= depool;
                end
                default: begin
                    abuf_conf_mode <= mode;
                    abuf_conf_mask <= mask;
                    abuf_conf_num  <= size;
                end
            endcase
        end
    end

    logic [DDR_ADDR_W-1:0] ch_addr  [DDR_CH_NUM];
    logic [DDR_ADDR_W-1:0] ch_step  [DDR_CH_NUM];
    logic [BURST_W-1:0]    ch_burst [DDR_CH_NUM];
    logic [BURST_W-1:0]    ch_bnum  [DDR_CH_NUM];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < DDR_CH_NUM; c++) begin
                ch_addr[c]  <= '0;
                ch_step[c]  <= '0;
                ch_burst[c] <= '0;
                ch_bnum[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < DDR_CH_NUM; c++) begin
                if (set_ch[c]) begin
                    ch_addr[c]  <= DDR_ADDR_W'(addr);
                    ch_step[c]  <= DDR_ADDR_W'(image_width);
                    ch_burst[c] <= BURST_W'(blen);
                    ch_bnum[c]  <= BURST_W'(size);
                end
            end
        end
    end

    for (genvar c = 0; c < DDR_CH_NUM; c++) begin : g_ch
        ddr2pe_busy_track u_busy (
            .clk  (clk),
            .rst  (rst),
            .set  (set_ch[c]),
            .clr  (ddr_done[c]),
            .busy (busy_ch[c])
        );
        assign ddr_st_addr[c*DDR_ADDR_W +: DDR_ADDR_W] = ch_addr[c];
        assign ddr_step[c*DDR_ADDR_W +: DDR_ADDR_W]    = ch_step[c];
        assign ddr_burst[c*BURST_W +: BURST_W]         = ch_burst[c];
        assign ddr_burst_num[c*BURST_W +: BURST_W]     = ch_bnum[c];
    end

    // Starts follow the accept edge by one cycle, after the conf registers are already stable
    logic [3:0] start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q   <= '0;
            ddr_start <= '0;
            ins_err   <= 1'b0;
        end else begin
            start_q   <= set_buf;
            ddr_start <= set_ch;
            ins_err   <= accept && err;
        end
    end

    assign {abuf_start, pbuf_start, dbuf_start, ibuf_start} = start_q;

endmodule
